// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader and the instruction decoder.
package program_loader_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 2;
  localparam int unsigned DEPTH  = 4;
  // Wide enough to hold the count DEPTH itself, not just DEPTH-1.
  localparam int unsigned CNT_W  = 3;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StArm  = 2'd2,
    StRun  = 2'd3
  } state_e;

  // Instruction opcodes, shared with the decoder.
  localparam data_t OpNop = 2'b00;
  localparam data_t OpInc = 2'b01;
  localparam data_t OpDec = 2'b10;
  localparam data_t OpJmp = 2'b11;

endpackage

// File: rtl/program_loader_if.sv
// Write handshake and program-counter read port of the program loader.
interface program_loader_if;
  import program_loader_pkg::*;

  logic  wr_valid;
  data_t wr_data;
  logic  wr_ready;
  addr_t rd_addr;
  data_t rd_data;

  modport master (
    output wr_valid,
    output wr_data,
    output rd_addr,
    input  wr_ready,
    input  rd_data
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  rd_addr,
    output wr_ready,
    output rd_data
  );

endinterface

// File: rtl/program_loader_prog_ram.sv
// Program RAM: register file with one synchronous write port and one asynchronous read port.
module prog_ram #(
  parameter int unsigned AddrW = 2,
  parameter int unsigned DataW = 2,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [DataW-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [DataW-1:0] rdata
);

  logic [DataW-1:0] mem_q [Depth];

  // Storage: cleared by reset, written on enabled edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Reading the entry being written returns the old value until the edge.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/program_loader.sv
// Program loader: fills the program RAM over valid/ready, then releases the core with a start pulse.
module program_loader
  import program_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   load_req,
  program_loader_if.slave        bus,
  output logic                   cpu_hold,
  output logic                   cpu_start,
  output logic [CNT_W-1:0]       words_loaded,
  output logic                   err_overrun
);

  localparam cnt_t CntFull = cnt_t'(DEPTH);

  state_e state_q, state_d;
  addr_t  wr_ptr_q, wr_ptr_d;
  cnt_t   cnt_q, cnt_d;
  logic   err_q, err_d;
  logic   wr_ready;
  logic   xfer;

  // Next-state, pointer/count updates and state-decoded outputs; clk_en gates every change.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    wr_ready  = 1'b0;
    cpu_start = 1'b0;
    cpu_hold  = 1'b1;
    xfer      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (clk_en && load_req) begin
          state_d  = StLoad;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end
      end
      StLoad: begin
        wr_ready = clk_en;
        xfer     = bus.wr_valid & clk_en;
        if (xfer) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
          // A word accepted as load_req falls still counts, so the load is non-empty.
          if (cnt_d == CntFull || !load_req) begin
            state_d = StArm;
          end
        end else if (clk_en && !load_req) begin
          state_d = (cnt_q != '0) ? StArm : StIdle;
        end
      end
      StArm: begin
        cpu_start = clk_en;
        if (clk_en) begin
          state_d = StRun;
        end
      end
      StRun: begin
        cpu_hold = 1'b0;
        if (clk_en && load_req) begin
          state_d  = StLoad;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Words offered outside LOAD are dropped and flagged until reset.
    if (clk_en && bus.wr_valid && state_q != StLoad) begin
      err_d = 1'b1;
    end
  end

  // State, pointer, count and sticky error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  prog_ram #(
    .AddrW (ADDR_W),
    .DataW (DATA_W),
    .Depth (DEPTH)
  ) u_prog_ram (
    .clk   (clk),
    .reset (reset),
    .we    (xfer),
    .waddr (wr_ptr_q),
    .wdata (bus.wr_data),
    .raddr (bus.rd_addr),
    .rdata (bus.rd_data)
  );

  assign bus.wr_ready  = wr_ready;
  assign words_loaded  = cnt_q;
  assign err_overrun   = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed, table-driven bench for program_loader.
module tb_program_loader;
  import program_loader_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_en;
  logic       load_req;
  logic       cpu_hold;
  logic       cpu_start;
  logic [2:0] words_loaded;
  logic       err_overrun;

  program_loader_if bus ();

  program_loader dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .load_req     (load_req),
    .bus          (bus.slave),
    .cpu_hold     (cpu_hold),
    .cpu_start    (cpu_start),
    .words_loaded (words_loaded),
    .err_overrun  (err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lr;
    logic       en;
    logic       vl;
    logic [1:0] wd;
    logic [1:0] ra;
    logic       rdy;
    logic       hold;
    logic       st;
    logic [2:0] w;
    logic [1:0] rd;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(int lr, int en, int vl, int wd, int ra,
                              int rdy, int hold, int st, int w, int rd, int err);
    vec_t v;
    v.lr = 1'(lr); v.en = 1'(en); v.vl = 1'(vl); v.wd = 2'(wd); v.ra = 2'(ra);
    v.rdy = 1'(rdy); v.hold = 1'(hold); v.st = 1'(st); v.w = 3'(w);
    v.rd = 2'(rd); v.err = 1'(err);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    clk_en       = 1'b1;
    load_req     = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 2'b00;
    bus.rd_addr  = 2'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_hold", 0, 8'(cpu_hold), 8'h1);
    check("rst_ready", 0, 8'(bus.wr_ready), 8'h0);
    check("rst_start", 0, 8'(cpu_start), 8'h0);
    check("rst_words", 0, 8'(words_loaded), 8'h0);
    check("rst_err", 0, 8'(err_overrun), 8'h0);
    for (int a = 0; a < 4; a++) begin
      bus.rd_addr = 2'(a);
      #1 check("rst_rd", a, 8'(bus.rd_data), 8'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    //          lr en vl wd ra   rdy hold st w  rd err
    // Full load 01,10,11,00, readback, overrun in RUN.
    vecs.push_back(mk(1, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0,   1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 2, 0,   1, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1, 1, 1, 3, 1,   1, 1, 0, 2, 2, 0));
    vecs.push_back(mk(1, 1, 1, 0, 2,   1, 1, 0, 3, 3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 3,   0, 1, 1, 4, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,   0, 0, 0, 4, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1,   0, 0, 0, 4, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2,   0, 0, 0, 4, 3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 3,   0, 0, 0, 4, 0, 0));
    vecs.push_back(mk(0, 1, 1, 2, 2,   0, 0, 0, 4, 3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 2,   0, 0, 0, 4, 3, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0,   0, 0, 0, 4, 1, 1));
    // Reload from RUN with 11,11,11,11.
    vecs.push_back(mk(1, 1, 0, 0, 0,   0, 0, 0, 4, 1, 1));
    vecs.push_back(mk(1, 1, 1, 3, 0,   1, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 3, 0,   1, 1, 0, 1, 3, 1));
    vecs.push_back(mk(1, 1, 1, 3, 0,   1, 1, 0, 2, 3, 1));
    vecs.push_back(mk(1, 1, 1, 3, 3,   1, 1, 0, 3, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 3,   0, 1, 1, 4, 3, 1));
    // Partial load 01,10; load_req falls with the second word.
    vecs.push_back(mk(1, 1, 0, 0, 0,   0, 0, 0, 4, 3, 1));
    vecs.push_back(mk(1, 1, 1, 1, 0,   1, 1, 0, 0, 3, 1));
    vecs.push_back(mk(0, 1, 1, 2, 1,   1, 1, 0, 1, 3, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0,   0, 1, 1, 2, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 1,   0, 0, 0, 2, 2, 1));
    vecs.push_back(mk(0, 1, 0, 0, 2,   0, 0, 0, 2, 3, 1));
    vecs.push_back(mk(0, 1, 0, 0, 3,   0, 0, 0, 2, 3, 1));
    // clk_en low for 3 cycles mid-LOAD, then resume at the same pointer.
    vecs.push_back(mk(1, 1, 0, 0, 0,   0, 0, 0, 2, 1, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0,   1, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 3, 1,   0, 1, 0, 1, 2, 1));
    vecs.push_back(mk(1, 0, 1, 3, 2,   0, 1, 0, 1, 3, 1));
    vecs.push_back(mk(1, 0, 1, 3, 0,   0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(1, 1, 1, 1, 1,   1, 1, 0, 1, 2, 1));
    vecs.push_back(mk(0, 1, 0, 0, 1,   1, 1, 0, 2, 1, 1));
    // ARM frozen by clk_en: start suppressed, then delivered once enabled.
    vecs.push_back(mk(0, 0, 0, 0, 2,   0, 1, 0, 2, 3, 1));
    vecs.push_back(mk(0, 1, 0, 0, 2,   0, 1, 1, 2, 3, 1));
    // Empty load: load_req drops before any word -> back to IDLE.
    vecs.push_back(mk(1, 1, 0, 0, 3,   0, 0, 0, 2, 3, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0,   0, 1, 0, 0, 0, 1));

    foreach (vecs[i]) begin
      @(negedge clk);
      load_req     = vecs[i].lr;
      clk_en       = vecs[i].en;
      bus.wr_valid = vecs[i].vl;
      bus.wr_data  = vecs[i].wd;
      bus.rd_addr  = vecs[i].ra;
      #1;
      check("wr_ready", i, 8'(bus.wr_ready), 8'(vecs[i].rdy));
      check("cpu_hold", i, 8'(cpu_hold), 8'(vecs[i].hold));
      check("cpu_start", i, 8'(cpu_start), 8'(vecs[i].st));
      check("words_loaded", i, 8'(words_loaded), 8'(vecs[i].w));
      check("rd_data", i, 8'(bus.rd_data), 8'(vecs[i].rd));
      check("err_overrun", i, 8'(err_overrun), 8'(vecs[i].err));
    end

    // Asynchronous reset in the cycle after the second write of a load.
    @(negedge clk);
    load_req     = 1'b1;
    clk_en       = 1'b1;
    bus.wr_valid = 1'b0;
    @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 2'b01;
    @(negedge clk);
    bus.wr_data  = 2'b10;
    @(posedge clk);
    #2;
    check("pre_rst_words", 0, 8'(words_loaded), 8'h2);
    check("pre_rst_ready", 0, 8'(bus.wr_ready), 8'h1);
    reset = 1'b1;
    #1;
    check("async_rst_hold", 0, 8'(cpu_hold), 8'h1);
    check("async_rst_ready", 0, 8'(bus.wr_ready), 8'h0);
    check("async_rst_words", 0, 8'(words_loaded), 8'h0);
    check("async_rst_err", 0, 8'(err_overrun), 8'h0);
    for (int a = 0; a < 4; a++) begin
      bus.rd_addr = 2'(a);
      #1 check("async_rst_rd", a, 8'(bus.rd_data), 8'h0);
    end
    @(negedge clk);
    reset        = 1'b0;
    load_req     = 1'b0;
    bus.wr_valid = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_hold", 0, 8'(cpu_hold), 8'h1);
    check("post_rst_ready", 0, 8'(bus.wr_ready), 8'h0);
    check("post_rst_start", 0, 8'(cpu_start), 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
